// File: rtl/head_vector_extract.sv
// head_vector_extract: gathers one header byte per field into an 80-bit head vector
module head_vector_extract #(
    parameter int         FIELDS     = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SKIP_OFF   = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   headVectorLocation_valid,
    input  logic [8*FIELDS+12:0]   headVectorLocation,
    output logic                   pkt_rd_en,
    output logic [12:0]            pkt_rd_addr,
    input  logic [7:0]             pkt_rd_data,
    output logic                   head_vector_valid,
    output logic [4:0]             head_vector_id,
    output logic [7:0]             head_vector_index,
    output logic [8*FIELDS-1:0]    head_vector,
    output logic [15:0]            drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIELDS);
    localparam int IX = 8 * FIELDS;
    localparam int W  = 8 * FIELDS + 13;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_t;

    logic [W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [AW:0]    r_count;
    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt, w_cnt_n, r_d_slot;
    logic [W-1:0]   r_work, w_work_n;
    logic [IX-1:0]  r_res, w_res_n;
    logic [7:0]     w_off_n;
    logic           r_d_en;
    logic           w_empty, w_full, w_pop, w_push, w_drop;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_pop   = (r_state == IDLE || r_state == EMIT) && !w_empty;
    assign w_push  = headVectorLocation_valid && (!w_full || w_pop);
    assign w_drop  = headVectorLocation_valid && !w_push;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= headVectorLocation;
    end

    // FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // next state, next field and result assembly; EMIT pops directly to avoid a bubble
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, EMIT: w_next = w_empty ? IDLE : READ;
            READ:       w_next = (r_cnt == CW'(FIELDS - 1)) ? DRAIN : READ;
            DRAIN:      w_next = EMIT;
            default:    w_next = IDLE;
        endcase
        w_cnt_n  = w_pop ? '0 : (r_state == READ ? r_cnt + 1'b1 : r_cnt);
        w_work_n = w_pop ? r_mem[r_rp] : r_work;
        w_off_n  = w_work_n[8*w_cnt_n +: 8];
        w_res_n  = r_res;
        if (w_pop) w_res_n = '0;
        else if (r_d_en) w_res_n[8*r_d_slot +: 8] = pkt_rd_data;
    end

    // FSM state, read strobe registered for the field about to be read, and delayed capture tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_res       <= '0;
            pkt_rd_en   <= 1'b0;
            pkt_rd_addr <= '0;
            r_d_en      <= 1'b0;
            r_d_slot    <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_n;
            r_work      <= w_work_n;
            r_res       <= w_res_n;
            pkt_rd_en   <= w_next == READ && w_off_n != SKIP_OFF;
            pkt_rd_addr <= w_next == READ ? {w_work_n[W-1:IX+8], w_off_n} : pkt_rd_addr;
            r_d_en      <= pkt_rd_en;
            r_d_slot    <= r_cnt;
        end
    end

    // result outputs load as DRAIN captures the last byte, so valid is high during EMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_vector_valid <= 1'b0;
            head_vector_id    <= '0;
            head_vector_index <= '0;
            head_vector       <= '0;
        end else begin
            head_vector_valid <= r_state == DRAIN;
            if (r_state == DRAIN) begin
                head_vector       <= w_res_n;
                head_vector_id    <= r_work[W-1:IX+8];
                head_vector_index <= r_work[IX+7:IX];
            end
        end
    end
endmodule

// File: tb/tb_head_vector_extract.sv
// tb_head_vector_extract: directed checks of head vector gathering, FIFO drops and reset
module tb_head_vector_extract;
    logic        clk = 1'b0;
    logic        reset;
    logic        headVectorLocation_valid;
    logic [92:0] headVectorLocation;
    logic        pkt_rd_en;
    logic [12:0] pkt_rd_addr;
    logic [7:0]  pkt_rd_data = 8'hEE;
    logic        head_vector_valid;
    logic [4:0]  head_vector_id;
    logic [7:0]  head_vector_index;
    logic [79:0] head_vector;
    logic [15:0] drop_cnt;

    typedef struct {int c; logic [4:0] id; logic [7:0] idx; logic [79:0] hv;} res_t;
    res_t q[$];
    int cyc = 0;
    int nrd = 0;
    int total = 0;
    int bad = 0;

    head_vector_extract dut (
        .clk(clk), .reset(reset),
        .headVectorLocation_valid(headVectorLocation_valid),
        .headVectorLocation(headVectorLocation),
        .pkt_rd_en(pkt_rd_en), .pkt_rd_addr(pkt_rd_addr), .pkt_rd_data(pkt_rd_data),
        .head_vector_valid(head_vector_valid), .head_vector_id(head_vector_id),
        .head_vector_index(head_vector_index), .head_vector(head_vector),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] buf_byte(input logic [12:0] a);
        return a[7:0] + 8'h10 + {3'b000, a[12:8]} - 8'd5;
    endfunction

    function automatic logic [79:0] ramp(input logic [7:0] base);
        logic [79:0] o;
        for (int i = 0; i < 10; i++) o[8*i +: 8] = base + 8'(i);
        return o;
    endfunction

    function automatic logic [79:0] exp_hv(input logic [4:0] id, input logic [79:0] offs);
        logic [79:0] o;
        for (int i = 0; i < 10; i++)
            o[8*i +: 8] = offs[8*i +: 8] == 8'hFF ? 8'h00 : buf_byte({id, offs[8*i +: 8]});
        return o;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pkt_rd_data <= pkt_rd_en ? buf_byte(pkt_rd_addr) : 8'hEE;
    end

    always @(negedge clk) begin
        if (head_vector_valid) q.push_back('{cyc + 1, head_vector_id, head_vector_index, head_vector});
        if (pkt_rd_en) nrd <= nrd + 1;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] id, input logic [7:0] idx, input logic [79:0] offs);
        @(negedge clk);
        headVectorLocation_valid = 1'b1;
        headVectorLocation = {id, idx, offs};
        @(negedge clk);
        headVectorLocation_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int c, input logic [4:0] id,
                           input logic [7:0] idx, input logic [79:0] hv);
        res_t r;
        r = '{0, 5'd0, 8'd0, 80'd0};
        if (q.size() > 0) r = q.pop_front();
        check({tag, "_cycle"}, r.c, c);
        check({tag, "_id"}, r.id, id);
        check({tag, "_idx"}, r.idx, idx);
        check({tag, "_hv"}, r.hv, hv);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_valid"}, head_vector_valid, 0);
        check({tag, "_id"}, head_vector_id, 0);
        check({tag, "_idx"}, head_vector_index, 0);
        check({tag, "_hv"}, head_vector, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_rden"}, pkt_rd_en, 0);
    endtask

    initial begin
        int e, n0;
        logic [79:0] offs;
        reset = 1'b1;
        headVectorLocation_valid = 1'b0;
        headVectorLocation = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        check("rst_addr", pkt_rd_addr, 0);
        reset = 1'b0;

        n0 = nrd;
        send(5'd5, 8'h21, ramp(8'h00));
        e = cyc;
        repeat (20) @(negedge clk);
        check("t1_nres", q.size(), 1);
        pop_chk("t1", e + 13, 5'd5, 8'h21, 80'h19181716151413121110);
        check("t1_reads", nrd - n0, 10);

        n0 = nrd;
        send(5'd3, 8'h07, {10{8'hFF}});
        e = cyc;
        repeat (20) @(negedge clk);
        check("t2_nres", q.size(), 1);
        pop_chk("t2", e + 13, 5'd3, 8'h07, 80'h0);
        check("t2_reads", nrd - n0, 0);

        n0 = nrd;
        offs = ramp(8'h40);
        offs[31:24] = 8'hFF;
        send(5'd5, 8'h44, offs);
        e = cyc;
        repeat (20) @(negedge clk);
        check("t4_nres", q.size(), 1);
        pop_chk("t4", e + 13, 5'd5, 8'h44, 80'h59585756555400525150);
        check("t4_reads", nrd - n0, 9);

        e = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) e = cyc + 1;
            headVectorLocation_valid = 1'b1;
            headVectorLocation = {5'(j + 1), 8'(8'h30 + j), ramp(8'(16 * j))};
        end
        @(negedge clk);
        headVectorLocation_valid = 1'b0;
        repeat (80) @(negedge clk);
        check("t3_drop", drop_cnt, 1);
        check("t3_nres", q.size(), 5);
        for (int k = 0; k < 5; k++)
            pop_chk($sformatf("t3_r%0d", k), e + 13 + 12 * k, 5'(k + 1), 8'(8'h30 + k),
                    exp_hv(5'(k + 1), ramp(8'(16 * k))));
        check("hold_valid", head_vector_valid, 0);
        check("hold_id", head_vector_id, 5);
        check("hold_idx", head_vector_index, 8'h34);

        send(5'd9, 8'h55, ramp(8'h20));
        e = cyc;
        while (cyc < e + 7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero("t5_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_nres_after_rst", q.size(), 0);
        send(5'd9, 8'h56, ramp(8'h20));
        e = cyc;
        repeat (20) @(negedge clk);
        check("t5_nres", q.size(), 1);
        pop_chk("t5", e + 13, 5'd9, 8'h56, exp_hv(5'd9, ramp(8'h20)));

        send(5'd2, 8'h61, ramp(8'h30));
        e = cyc;
        while (cyc < e + 11) @(negedge clk);
        send(5'd4, 8'h62, ramp(8'h38));
        repeat (30) @(negedge clk);
        check("t6_nres", q.size(), 2);
        pop_chk("t6a", e + 13, 5'd2, 8'h61, exp_hv(5'd2, ramp(8'h30)));
        pop_chk("t6b", e + 26, 5'd4, 8'h62, exp_hv(5'd4, ramp(8'h38)));
        check("t6_drop", drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
